// File: rtl/decod_scan_seq.sv
// rtl/decod_scan_seq.sv - scan sequencer driving a 4-to-16 enabled line decoder
// Walks the masked lines in ascending order with a one-cycle gap before each enable.
module decod_scan_seq #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          continuous,
  input  logic [15:0]   mask,
  input  logic [DW-1:0] dwell,
  output logic [3:0]    addr,
  output logic          en,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          wrap
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GAP   = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   smask_q, smask_d;
  logic [DW-1:0] sdwell_q, sdwell_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [3:0]    addr_q, addr_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic          wrap_q, wrap_d;

  logic [15:0]   higher;
  logic          has_higher;

  function automatic logic [3:0] lowest_bit(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Lines strictly above the current one that are still to be visited this pass.
  assign higher     = smask_q & (16'hFFFE << addr_q);
  assign has_higher = |higher;

  always_comb begin
    state_d   = state_q;
    smask_d   = smask_q;
    sdwell_d  = sdwell_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    wrap_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mask != 16'h0000) begin
            smask_d  = mask;
            sdwell_d = dwell;
            addr_d   = lowest_bit(mask);
            state_d  = S_GAP;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (stop) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else begin
          cnt_d   = sdwell_q;
          state_d = S_DRIVE;
        end
      end

      S_DRIVE: begin
        if (stop) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DW'(1);
        end else if (has_higher) begin
          addr_d  = lowest_bit(higher);
          state_d = S_GAP;
        end else if (continuous) begin
          addr_d  = lowest_bit(smask_q);
          wrap_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    en_d   = (state_d == S_DRIVE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      smask_q   <= 16'h0000;
      sdwell_q  <= '0;
      cnt_q     <= '0;
      addr_q    <= 4'd0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      smask_q   <= smask_d;
      sdwell_q  <= sdwell_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      wrap_q    <= wrap_d;
    end
  end

  assign addr    = addr_q;
  assign en      = en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_decod_scan_seq.sv
// tb/tb_decod_scan_seq.sv - directed and randomized checks for decod_scan_seq
module tb_decod_scan_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] mask = 16'h0000;
  logic [7:0]  dwell = 8'd0;
  logic [3:0]  addr;
  logic        en, busy, done, aborted, wrap;

  int n_checks = 0;
  int n_errors = 0;

  decod_scan_seq #(.DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .mask       (mask),
    .dwell      (dwell),
    .addr       (addr),
    .en         (en),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int e_addr, input int e_en, input int e_busy,
                            input int e_done, input int e_ab, input int e_wrap);
    chk({tag, " addr"},    32'(addr),    32'(e_addr));
    chk({tag, " en"},      32'(en),      32'(e_en));
    chk({tag, " busy"},    32'(busy),    32'(e_busy));
    chk({tag, " done"},    32'(done),    32'(e_done));
    chk({tag, " aborted"}, 32'(aborted), 32'(e_ab));
    chk({tag, " wrap"},    32'(wrap),    32'(e_wrap));
  endtask

  int b_addr[10] = '{0, 0, 0, 0, 2, 2, 2, 2, 2, 2};
  int b_en[10]   = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 0};
  int b_busy[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int b_done[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

  int w_addr[13] = '{0, 0, 15, 15, 0, 0, 15, 15, 0, 0, 15, 15, 15};
  int w_en[13]   = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  int w_wrap[13] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0};

  int i_addr[7] = '{0, 0, 0, 1, 1, 1, 1};
  int i_en[7]   = '{0, 1, 1, 0, 1, 1, 0};
  int i_busy[7] = '{1, 1, 1, 1, 1, 1, 0};
  int i_done[7] = '{0, 0, 0, 0, 0, 0, 1};

  logic       prev_en;
  logic [3:0] prev_addr;
  logic       prev_busy;

  initial begin
    repeat (2) @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-line pass
    mask = 16'h0005; dwell = 8'd2; continuous = 1'b0; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      check_outs($sformatf("basic c%0d", c), b_addr[c-1], b_en[c-1], b_busy[c-1], b_done[c-1], 0, 0);
    end

    // Continuous scan over lines 0 and 15, then drop continuous
    mask = 16'h8001; dwell = 8'd0; continuous = 1'b1; start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start = 1'b0;
      check_outs($sformatf("wrap c%0d", c), w_addr[c-1], w_en[c-1], (c == 13) ? 0 : 1,
                 (c == 13) ? 1 : 0, 0, w_wrap[c-1]);
      if (c == 10) continuous = 1'b0;
    end

    // Abort in the third DRIVE cycle of line 1, then restart right away
    mask = 16'hFFFF; dwell = 8'd5; start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
      check_outs($sformatf("abort c%0d", c), (c >= 8) ? 1 : 0, (c == 1 || c == 8) ? 0 : 1, 1, 0, 0, 0);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_outs("abort end", 1, 0, 0, 1, 1, 0);
    mask = 16'h0010; dwell = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_outs("restart gap", 4, 0, 1, 0, 0, 0);
    @(negedge clk);
    check_outs("restart d0", 4, 1, 1, 0, 0, 0);
    @(negedge clk);
    check_outs("restart d1", 4, 1, 1, 0, 0, 0);
    @(negedge clk);
    check_outs("restart end", 4, 0, 0, 1, 0, 0);

    // Stop lands on the same edge as a wrap: abort wins, no wrap
    mask = 16'h8001; dwell = 8'd0; continuous = 1'b1; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      check_outs($sformatf("stopwrap c%0d", c), (c >= 3) ? 15 : 0, (c == 2 || c == 4) ? 1 : 0, 1, 0, 0, 0);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; continuous = 1'b0;
    check_outs("stopwrap end", 15, 0, 0, 1, 1, 0);

    // Empty mask
    @(negedge clk);
    mask = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_outs("empty c1", 15, 0, 0, 1, 0, 0);
    @(negedge clk);
    check_outs("empty c2", 15, 0, 0, 0, 0, 0);

    // Start together with stop in IDLE, then starts while busy are ignored
    mask = 16'h0003; dwell = 8'd1; start = 1'b1; stop = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      check_outs($sformatf("ignore c%0d", c), i_addr[c-1], i_en[c-1], i_busy[c-1], i_done[c-1], 0, 0);
      if (c == 2 || c == 5) begin
        start = 1'b1; mask = 16'hFFFF; dwell = 8'd0;
      end
    end

    // Reset in the middle of DRIVE
    @(negedge clk);
    mask = 16'hFFFF; dwell = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre-reset en", 32'(en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_outs("rst immediate", 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_outs($sformatf("rst held %0d", c), 0, 0, 0, 0, 0, 0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_outs($sformatf("rst after %0d", c), 0, 0, 0, 0, 0, 0);
    end

    // Randomized break-before-make
    prev_en = en; prev_addr = addr; prev_busy = busy;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (en) begin
        chk("bbm addr stable", 32'(addr), 32'(prev_addr));
        chk("en implies busy", 32'(busy), 32'd1);
        if (!prev_en) chk("gap before en", 32'(prev_busy), 32'd1);
      end
      prev_en = en; prev_addr = addr; prev_busy = busy;
      start      = ($urandom_range(0, 3) == 0);
      stop       = ($urandom_range(0, 29) == 0);
      continuous = ($urandom_range(0, 1) == 1);
      mask       = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      dwell      = 8'($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
